vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Downstream consumer of the pixel-rate tick.
- Counts horizontal and vertical pixel positions on each pclk tick and decodes them into hsync, vsync, display-enable, pixel coordinates and a frame-start strobe for the pixel-data path.
- Runs entirely in the system clk domain. pclk is used only as a one-cycle clock enable and is never used as a clock.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, level driven on h_sync/v_sync during the sync pulse

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- pclk  input  1  pixel tick: high for exactly one clk cycle per pixel period
- h_sync  output  1  horizontal sync
- v_sync  output  1  vertical sync
- de  output  1  display enable, high in the visible region only
- x_pixel  output  10  column, valid while de=1, otherwise 0
- y_pixel  output  10  row, valid while de=1, otherwise 0
- frame_start  output  1  one-clk strobe when position (0,0) is entered

Behaviour:
- Totals and widths:
  - H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
  - h_cnt and v_cnt are unsigned, wide enough for TOTAL-1 (10 bits at defaults).
- Reset (reset=0, asynchronous):
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1.
  - h_sync = v_sync = ~SYNC_ACTIVE, de = 0, x_pixel = y_pixel = 0, frame_start = 0.
  - Reset release takes effect on the first clk edge with reset=1.
- Advance:
  - On a clk edge with pclk=1: if h_cnt == H_TOTAL-1 then h_cnt ← 0, else h_cnt ← h_cnt + 1.
  - v_cnt increments (wrapping V_TOTAL-1 → 0) only on the tick where h_cnt wraps.
  - With pclk=0, every register holds its value.
- Per-axis phase FSM (VISIBLE → FRONT → SYNC → BACK → VISIBLE), transitions at counter boundaries:
  - VISIBLE: cnt < VIS
  - FRONT: VIS ≤ cnt < VIS+FP
  - SYNC: VIS+FP ≤ cnt < VIS+FP+SYNC
  - BACK: the remainder up to TOTAL-1
- Output timing:
  - All outputs are registered and decoded from the next-state counters.
  - They change on the same clk edge as h_cnt/v_cnt, so there is zero skew against the position. Latency from the pclk tick to the outputs is 1 clk.
- Output decode:
  - h_sync = SYNC_ACTIVE iff h phase is SYNC (h 656..751 at defaults); v_sync likewise (lines 490..491).
  - de = (h phase VISIBLE) && (v phase VISIBLE).
  - x_pixel = de ? h_cnt : 0; y_pixel = de ? v_cnt : 0.
  - frame_start = 1 for exactly the clk cycle following the tick that produces (0,0). This is also true of the first tick after reset.
- Boundary conditions:
  - pclk held high continuously: the block advances every clk, which is legal.
  - pclk stuck low: outputs freeze.
  - Reset asserted mid-frame: immediate return to reset values. The next tick yields (0,0) with frame_start.

Decomposition:
- Package vga_pkg holds:
  - default timing constants and derived H_TOTAL/V_TOTAL
  - typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} vga_phase_e
- One sub-module, vga_axis_counter:
  - Parameterised by VIS/FP/SYNC/BP; ports clk, reset, en.
  - Outputs cnt, phase, wrap.
  - Instantiated twice: H with en=pclk; V with en=pclk & h_wrap.

Test Plan:
- Reset, then pclk every 4th clk → before the first tick de=0 and h_sync=v_sync=1. One clk after the first tick: x=0, y=0, de=1, frame_start=1 for one cycle only.
- Run one line → de high for 640 ticks. h_sync low exactly for h=656..751 (96 ticks). Line period is 800 ticks = 3200 clk.
- Run a full frame → de-high ticks total 307200. v_sync low for lines 490–491 (1600 ticks). frame_start every 420000 ticks, exactly once per frame.
- Hold pclk=0 for 50 clk mid-line at x=123 → all outputs unchanged. The next tick gives x=124.
- Assert reset at (300,200) asynchronously between clk edges → outputs reach reset values immediately. After release, the first tick gives (0,0) and frame_start.
- pclk tied high → the full frame completes in 420000 clk with identical sync/de positions.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and the per-axis phase encoding.
// Imported by the axis counter and the sync generator top.
package vga_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;

    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        VISIBLE,
        FRONT,
        SYNC,
        BACK
    } vga_phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus VISIBLE/FRONT/SYNC/BACK phase FSM.
// cnt/phase report the values taken on this edge so the top can register decodes in lockstep.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VIS    = DEF_H_VISIBLE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC_W = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned TOTAL  = VIS + FP + SYNC_W + BP,
    parameter int unsigned W      = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output vga_phase_e   phase,
    output logic         wrap
);

    localparam logic [W-1:0] LAST        = W'(TOTAL - 1);
    localparam logic [W-1:0] FRONT_START = W'(VIS);
    localparam logic [W-1:0] SYNC_START  = W'(VIS + FP);
    localparam logic [W-1:0] BACK_START  = W'(VIS + FP + SYNC_W);

    logic [W-1:0] cnt_q, cnt_d;
    vga_phase_e   phase_q, phase_d;

    assign wrap = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Each phase is left when the counter reaches the first position of the next one;
    // every porch and pulse is assumed to be at least one unit long.
    always_comb begin
        phase_d = phase_q;
        if (en) begin
            case (phase_q)
                VISIBLE: if (cnt_d == FRONT_START) phase_d = FRONT;
                FRONT:   if (cnt_d == SYNC_START)  phase_d = SYNC;
                SYNC:    if (cnt_d == BACK_START)  phase_d = BACK;
                BACK:    if (cnt_d == '0)          phase_d = VISIBLE;
                default:                           phase_d = BACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= LAST;
            phase_q <= BACK;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign cnt   = cnt_d;
    assign phase = phase_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator in the clk domain, advanced by the one-cycle pclk enable.
// Outputs are registered from next-state position so they move on the same edge as the counters.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pclk,
    output logic       h_sync,
    output logic       v_sync,
    output logic       de,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    vga_phase_e     h_phase, v_phase;
    logic           h_wrap, v_wrap;
    logic           v_en;

    logic       h_sync_d, v_sync_d, de_d, frame_start_d;
    logic [9:0] x_pixel_d, y_pixel_d;

    assign v_en = pclk & h_wrap;

    vga_axis_counter #(
        .VIS    (H_VISIBLE),
        .FP     (H_FP),
        .SYNC_W (H_SYNC),
        .BP     (H_BP),
        .TOTAL  (H_TOTAL),
        .W      (H_W)
    ) u_h_axis (
        .clk   (clk),
        .reset (reset),
        .en    (pclk),
        .cnt   (h_cnt),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .VIS    (V_VISIBLE),
        .FP     (V_FP),
        .SYNC_W (V_SYNC),
        .BP     (V_BP),
        .TOTAL  (V_TOTAL),
        .W      (V_W)
    ) u_v_axis (
        .clk   (clk),
        .reset (reset),
        .en    (v_en),
        .cnt   (v_cnt),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    // Decodes hold naturally while pclk is low because the next-state position is unchanged;
    // frame_start is the exception and must only fire on the tick that wraps both axes.
    always_comb begin
        h_sync_d      = (h_phase == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        v_sync_d      = (v_phase == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        de_d          = (h_phase == VISIBLE) && (v_phase == VISIBLE);
        x_pixel_d     = '0;
        y_pixel_d     = '0;
        if (de_d) begin
            x_pixel_d = 10'(h_cnt);
            y_pixel_d = 10'(v_cnt);
        end
        frame_start_d = h_wrap & v_wrap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_sync      <= ~SYNC_ACTIVE;
            v_sync      <= ~SYNC_ACTIVE;
            de          <= 1'b0;
            x_pixel     <= '0;
            y_pixel     <= '0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= h_sync_d;
            v_sync      <= v_sync_d;
            de          <= de_d;
            x_pixel     <= x_pixel_d;
            y_pixel     <= y_pixel_d;
            frame_start <= frame_start_d;
        end
    end

endmodule
